imem_boot_loader: RTL and testbench

//   Upstream loader for the single-cycle CPU: receives a program as a byte stream, packs it into
//   32-bit words and writes them into instruction memory from address 0.

---
 rtl/imem_boot_loader_pkg.sv | 21 ++
 rtl/imem_byte_packer.sv | 43 ++++
 rtl/imem_boot_loader.sv | 172 +++++++++++++++++
 tb/tb_imem_boot_loader.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_e        : loader FSM states (HDR, DATA, CHK, DONE, ERR)
//   BYTES_PER_WORD : bytes packed into one instruction word
//   hdr_bytes()    : number of header bytes on the link for a given count-field width
package imem_boot_loader_pkg;

  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    StHdr,
    StData,
    StChk,
    StDone,
    StErr
  } state_e;

  function automatic int unsigned hdr_bytes(input int unsigned cnt_w);
    return cnt_w / 8;
  endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words (first byte -> [31:24]).
// Ports:
//   clk_i        : clock
//   rst_i        : asynchronous active-low reset
//   clr_i        : synchronous clear of the byte counter (held by the FSM outside data phase)
//   byte_i       : incoming byte
//   strobe_i     : byte_i is consumed this cycle
//   word_o       : assembled word, valid together with word_valid_o
//   word_valid_o : single-cycle pulse on the cycle the 4th byte of a word is consumed
module imem_byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic [7:0]  byte_i,
  input  logic        strobe_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  r_cnt;
  logic [23:0] r_buf;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_cnt <= '0;
      r_buf <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
      r_buf <= '0;
    end else if (strobe_i) begin
      r_cnt <= r_cnt + 2'd1;
      r_buf <= {r_buf[15:0], byte_i};
    end
  end

  // The word is presented combinationally with its last byte so the caller can register it
  // on the same edge that accepts that byte.
  assign word_o       = {r_buf, byte_i};
  assign word_valid_o = strobe_i && (r_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a program over a byte link, writes it into instruction memory from
// address 0 and holds the CPU in reset until the whole image has been written.
// Link format: CNT_W/8 header bytes (word count N, MSB first), then 4*N data bytes,
// then (only when BOOT_CHECKSUM_EN is defined) one checksum byte = sum of data bytes mod 256.
// Optional feature macro: BOOT_CHECKSUM_EN.
// Ports:
//   clk_i, rst_i (async, active-low)
//   byte_valid_i/byte_data_i/byte_ready_o : host byte link, transfer on valid & ready
//   imem_we_o/imem_addr_o/imem_data_o     : instruction-memory write port (registered)
//   cpu_rst_o                             : CPU reset, active-low
//   done_o / err_o                        : load complete / load failed (both sticky)
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 128,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic        byte_ready_o,
  output logic        imem_we_o,
  output logic [31:0] imem_addr_o,
  output logic [31:0] imem_data_o,
  output logic        cpu_rst_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned HdrBytes = hdr_bytes(CNT_W);
  localparam int unsigned IdxW     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
`ifdef BOOT_CHECKSUM_EN
  localparam state_e PostData = StChk;
`else
  localparam state_e PostData = StDone;
`endif

  state_e           r_state;
  logic [3:0]       r_hdr_cnt;
  logic [CNT_W-1:0] r_n;
  logic [IdxW-1:0]  r_word_idx;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_data;
  logic             r_done;
  logic             r_cpu_rst;
  logic             r_err;
`ifdef BOOT_CHECKSUM_EN
  logic [7:0]       r_sum;
`endif

  logic             w_ready;
  logic             w_accept;
  logic             w_pack_clr;
  logic             w_pack_strobe;
  logic [31:0]      w_word;
  logic             w_word_valid;
  logic [CNT_W-1:0] w_n_next;
  logic             w_last_word;

  // Gating with rst_i makes ready drop immediately while reset is asserted.
  assign w_ready       = rst_i && (r_state inside {StHdr, StData, StChk});
  assign w_accept      = byte_valid_i && w_ready;
  assign w_pack_clr    = (r_state == StHdr);
  assign w_pack_strobe = w_accept && (r_state == StData);
  assign w_n_next      = CNT_W'({r_n, byte_data_i});
  assign w_last_word   = (CNT_W'(r_word_idx) == (r_n - CNT_W'(1)));

  imem_byte_packer u_packer (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        (w_pack_clr),
    .byte_i       (byte_data_i),
    .strobe_i     (w_pack_strobe),
    .word_o       (w_word),
    .word_valid_o (w_word_valid)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= StHdr;
      r_hdr_cnt  <= '0;
      r_n        <= '0;
      r_word_idx <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
      r_cpu_rst  <= 1'b0;
      r_err      <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        StHdr: begin
          if (w_accept) begin
            r_n <= w_n_next;
            if (r_hdr_cnt == 4'(HdrBytes - 1)) begin
              r_hdr_cnt <= '0;
              if (32'(w_n_next) > MAX_WORDS) begin
                r_state <= StErr;
                r_err   <= 1'b1;
              end else if (w_n_next == '0) begin
                r_state <= PostData;
              end else begin
                r_state <= StData;
              end
            end else begin
              r_hdr_cnt <= r_hdr_cnt + 4'd1;
            end
          end
        end
        StData: begin
`ifdef BOOT_CHECKSUM_EN
          if (w_accept) r_sum <= r_sum + byte_data_i;
`endif
          if (w_word_valid) begin
            r_we   <= 1'b1;
            r_addr <= 32'({r_word_idx, 2'b00});
            r_data <= w_word;
            if (w_last_word) begin
              r_state <= PostData;
            end else begin
              r_word_idx <= r_word_idx + 1'b1;
            end
          end
        end
        StChk: begin
`ifdef BOOT_CHECKSUM_EN
          if (w_accept) begin
            if (byte_data_i == r_sum) begin
              r_state   <= StDone;
              r_done    <= 1'b1;
              r_cpu_rst <= 1'b1;
            end else begin
              r_state <= StErr;
              r_err   <= 1'b1;
            end
          end
`else
          r_state <= StErr;
          r_err   <= 1'b1;
`endif
        end
        // Setting done here, not on the last data edge, keeps it off the final write cycle.
        StDone: begin
          r_done    <= 1'b1;
          r_cpu_rst <= 1'b1;
        end
        StErr: begin
          r_err <= 1'b1;
        end
        default: begin
          r_state <= StErr;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  assign byte_ready_o = w_ready;
  assign imem_we_o    = r_we;
  assign imem_addr_o  = r_addr;
  assign imem_data_o  = r_data;
  assign cpu_rst_o    = r_cpu_rst;
  assign done_o       = r_done;
  assign err_o        = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench for imem_boot_loader: expected memory writes are queued as each image is
// sent; an independent monitor pops and compares on every imem_we_o pulse.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] exp_q[$];

  // Test-1 image: header 00 02, then two words.
  logic [7:0] img1 [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                            8'h00, 8'h00, 8'h00, 8'h08};

  imem_boot_loader #(
    .MAX_WORDS (128),
    .CNT_W     (16)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .imem_we_o    (imem_we),
    .imem_addr_o  (imem_addr),
    .imem_data_o  (imem_data),
    .cpu_rst_o    (cpu_rst),
    .done_o       (done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  // Monitor: every write must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    logic [63:0] e;
    if (rst_n && imem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr %h data %h, required no write",
                 imem_addr, imem_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", imem_addr, e[63:32]);
        check("wr_data", imem_data, e[31:0]);
      end
      check_bit("done_low_during_we", done, 1'b0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    g = gaps ? int'($urandom_range(0, 3)) : 0;
    if (g > 0) begin
      byte_valid = 1'b0;
      repeat (g) @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    check_bit("byte_ready", byte_ready, 1'b1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
  endtask

  task automatic send_img1(input int first, input int last, input bit gaps);
    for (int i = first; i <= last; i++) send_byte(img1[i], gaps);
  endtask

  task automatic push_img1_writes();
    exp_q.push_back({32'h0000_0000, 32'h2008_0005});
    exp_q.push_back({32'h0000_0004, 32'h0000_0008});
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_bit("done_within_budget", done, 1'b1);
    check_bit("cpu_rst_released", cpu_rst, 1'b1);
  endtask

  task automatic do_reset();
    byte_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_bit("rst_we", imem_we, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_err", err, 1'b0);
    check_bit("rst_cpu_rst", cpu_rst, 1'b0);
    check_bit("rst_ready", byte_ready, 1'b0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check_bit("ready_after_rst", byte_ready, 1'b1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_bit("por_we", imem_we, 1'b0);
    check("por_addr", imem_addr, 32'h0);
    check_bit("por_done", done, 1'b0);
    check_bit("por_err", err, 1'b0);
    check_bit("por_cpu_rst", cpu_rst, 1'b0);
    rst_n = 1'b1;
    #1;
    check_bit("por_ready", byte_ready, 1'b1);

    // 1. Nominal load, no stalls
    push_img1_writes();
    send_img1(0, 9, 1'b0);
`ifdef BOOT_CHECKSUM_EN
    @(negedge clk);
    check_bit("t1_done_before_chk", done, 1'b0);
    @(posedge clk);
    #1;
    send_byte(8'h35, 1'b0);
    @(negedge clk);
    check_bit("t1_done", done, 1'b1);
    check_bit("t1_cpu_rst", cpu_rst, 1'b1);
`else
    @(negedge clk);
    check_bit("t1_done_not_with_we", done, 1'b0);
    check_bit("t1_cpu_rst_held", cpu_rst, 1'b0);
    @(negedge clk);
    check_bit("t1_done", done, 1'b1);
    check_bit("t1_cpu_rst", cpu_rst, 1'b1);
`endif
    check_bit("t1_ready_low", byte_ready, 1'b0);
    check("t1_sb_empty", 32'(exp_q.size()), 32'd0);

    // 2. Same image with random gaps
    do_reset();
    push_img1_writes();
    send_img1(0, 9, 1'b1);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h35, 1'b1);
`endif
    wait_done(10);
    check_bit("t2_err", err, 1'b0);
    check("t2_sb_empty", 32'(exp_q.size()), 32'd0);

    // 3. Overflow header 0x0081
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h81, 1'b0);
    @(negedge clk);
    check_bit("t3_err", err, 1'b1);
    check_bit("t3_ready", byte_ready, 1'b0);
    check_bit("t3_cpu_rst", cpu_rst, 1'b0);
    check_bit("t3_done", done, 1'b0);
    byte_valid = 1'b1;
    byte_data  = 8'hff;
    repeat (8) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    @(negedge clk);
    check_bit("t3_err_sticky", err, 1'b1);
    check_bit("t3_cpu_rst_sticky", cpu_rst, 1'b0);

    // 4. Empty image
    do_reset();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
`ifdef BOOT_CHECKSUM_EN
    @(negedge clk);
    check_bit("t4_done_before_chk", done, 1'b0);
    @(posedge clk);
    #1;
    send_byte(8'h00, 1'b0);
`endif
    wait_done(4);
    check_bit("t4_err", err, 1'b0);

    // 5. Reset after 5 data bytes, then full reload
    do_reset();
    exp_q.push_back({32'h0000_0000, 32'h2008_0005});
    send_img1(0, 6, 1'b0);
    @(negedge clk);
    check("t5_sb_empty_partial", 32'(exp_q.size()), 32'd0);
    check_bit("t5_cpu_rst_partial", cpu_rst, 1'b0);
    do_reset();
    push_img1_writes();
    send_img1(0, 9, 1'b0);
`ifdef BOOT_CHECKSUM_EN
    send_byte(8'h35, 1'b0);
`endif
    wait_done(4);
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);

`ifdef BOOT_CHECKSUM_EN
    // 6. Bad checksum: writes still happen, load fails
    do_reset();
    push_img1_writes();
    send_img1(0, 9, 1'b0);
    send_byte(8'h36, 1'b0);
    @(negedge clk);
    check_bit("t6_err", err, 1'b1);
    check_bit("t6_cpu_rst", cpu_rst, 1'b0);
    check_bit("t6_done", done, 1'b0);
    check_bit("t6_ready", byte_ready, 1'b0);
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
